// File: rtl/mseq_store_txn_sched.sv
// -----------------------------------------------------------------------------
// mseq_store_txn_sched
//
// Burst scheduler for the matrix sequential-store path. It takes one store
// request, given as a start address and a length, both in nibbles. It splits
// the request into AXI write bursts. A burst never crosses a BoundaryBytes
// boundary and never exceeds MaxBurstBeats beats. For each burst it issues
// one AW. It then emits one control record per W beat for the store datapath.
// It counts outstanding B responses and pulses done_o once the whole request
// has retired.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*               request handshake: nibble start address, nibble count
//   aw_*                AXI write-address channel (addr, len, size)
//   txn_*               per-beat control: burst start nibble address,
//                       head-of-burst flag, beats remaining after this one,
//                       exclusive upper nibble of the last beat, final-burst flag
//   b_valid_i, b_ready_o AXI write-response handshake
//   busy_o              scheduler is not idle
//   done_o              one-cycle pulse when the request has completed
// -----------------------------------------------------------------------------
module mseq_store_txn_sched #(
  parameter int unsigned AxiDataWidth   = 512,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned MaxBurstBeats  = 16,
  parameter int unsigned BoundaryBytes  = 4096,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned BusNibbles    = AxiDataWidth / 4,
  localparam int unsigned BusNSize      = $clog2(BusNibbles)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [AxiAddrWidth:0]     req_addr_i,
  input  logic [LenWidth-1:0]       req_nbs_i,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [AxiAddrWidth-1:0]   aw_addr_o,
  output logic [7:0]                aw_len_o,
  output logic [2:0]                aw_size_o,
  output logic                      txn_valid_o,
  input  logic                      txn_ready_i,
  output logic [AxiAddrWidth:0]     txn_addr_o,
  output logic                      txn_is_head_o,
  output logic [7:0]                txn_rmn_beat_o,
  output logic [BusNSize:0]         txn_lbn_o,
  output logic                      txn_is_final_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned AddrNbW    = AxiAddrWidth + 1;
  localparam int unsigned BndNibbles = 2 * BoundaryBytes;
  localparam int unsigned BndBits    = $clog2(BndNibbles);
  localparam int unsigned MaxNb      = MaxBurstBeats * BusNibbles;
  localparam int unsigned CalcWidth  = $clog2(BndNibbles + BusNibbles) + 1;
  // Burst arithmetic runs at a width that covers both the request length
  // and the boundary distance, so min() compares like with like.
  localparam int unsigned W          = (LenWidth > CalcWidth) ? LenWidth : CalcWidth;
  localparam int unsigned LbnW       = BusNSize + 1;
  localparam int unsigned OutWidth   = $clog2(MaxOutstanding + 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    AW,
    BEATS,
    WAIT_B
  } state_e;

  state_e                state, state_n;
  logic [AddrNbW-1:0]    cur_addr;
  logic [LenWidth-1:0]   rmn;
  logic [W-1:0]          chunk_q;
  logic [7:0]            len_q;
  logic [LbnW-1:0]       lbn_q;
  logic                  final_q;
  logic [7:0]            rmn_beat;
  logic                  is_head;
  logic [OutWidth-1:0]   outstanding;

  // Combinational burst fields, evaluated from cur_addr/rmn and latched in CALC.
  logic [W-1:0]          off, to_bnd, max_nb, rmn_w, chunk_c, end_m1;
  logic [7:0]            len_c;
  logic [LbnW-1:0]       lbn_c;
  logic                  final_c;

  logic aw_hs, b_hs;

  always_comb begin
    off     = W'(cur_addr[BusNSize-1:0]);
    to_bnd  = W'(BndNibbles) - W'(cur_addr[BndBits-1:0]);
    max_nb  = W'(MaxNb) - off;
    rmn_w   = W'(rmn);
    chunk_c = rmn_w;
    if (to_bnd < chunk_c) chunk_c = to_bnd;
    if (max_nb < chunk_c) chunk_c = max_nb;
    // The last nibble touched, counted from the start of the first beat.
    // chunk_c is at least 1, so this never wraps.
    end_m1  = off + chunk_c - W'(1);
    len_c   = 8'(end_m1 >> BusNSize);
    lbn_c   = LbnW'(end_m1[BusNSize-1:0]) + LbnW'(1);
    final_c = (rmn_w == chunk_c);
  end

  assign aw_hs = aw_valid_o & aw_ready_i;
  // A B arriving with nothing outstanding is a protocol error. It is ignored
  // here so the counter cannot wrap, and it is flagged by the property below.
  assign b_hs  = b_valid_i & b_ready_o & (outstanding != '0);

  // NOTE: every register below changes only through non-blocking
  // assignments, so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cur_addr    <= '0;
      rmn         <= '0;
      chunk_q     <= '0;
      len_q       <= '0;
      lbn_q       <= '0;
      final_q     <= 1'b0;
      rmn_beat    <= '0;
      is_head     <= 1'b0;
      outstanding <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            cur_addr <= req_addr_i;
            rmn      <= req_nbs_i;
          end
        end
        CALC: begin
          chunk_q  <= chunk_c;
          len_q    <= len_c;
          lbn_q    <= lbn_c;
          final_q  <= final_c;
          rmn_beat <= len_c;
          is_head  <= 1'b1;
        end
        BEATS: begin
          if (txn_ready_i) begin
            is_head <= 1'b0;
            if (rmn_beat != 8'd0) begin
              rmn_beat <= rmn_beat - 8'd1;
            end else begin
              cur_addr <= cur_addr + AddrNbW'(chunk_q);
              rmn      <= rmn - LenWidth'(chunk_q);
            end
          end
        end
        default: ;
      endcase

      unique case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + OutWidth'(1);
        2'b01:   outstanding <= outstanding - OutWidth'(1);
        default: ;
      endcase
    end
  end

  // NOTE: every output and state_n gets a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    state_n     = state;
    req_ready_o = 1'b0;
    aw_valid_o  = 1'b0;
    txn_valid_o = 1'b0;
    done_o      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_n = CALC;
      end
      CALC: begin
        if (outstanding < OutWidth'(MaxOutstanding)) state_n = AW;
      end
      AW: begin
        aw_valid_o = 1'b1;
        if (aw_ready_i) state_n = BEATS;
      end
      BEATS: begin
        // Beat control is only presented once this burst's AW has handshaken.
        txn_valid_o = 1'b1;
        if (txn_ready_i && (rmn_beat == 8'd0)) state_n = final_q ? WAIT_B : CALC;
      end
      WAIT_B: begin
        if (outstanding == '0) begin
          done_o  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign aw_addr_o      = cur_addr[AxiAddrWidth:1];
  assign aw_len_o       = len_q;
  assign aw_size_o      = 3'($clog2(AxiDataWidth / 8));
  assign txn_addr_o     = cur_addr;
  assign txn_is_head_o  = is_head;
  assign txn_rmn_beat_o = rmn_beat;
  assign txn_lbn_o      = lbn_q;
  assign txn_is_final_o = final_q;
  assign b_ready_o      = ~rst_i;
  assign busy_o         = (state != IDLE);

  b_without_outstanding : assert property (
    @(posedge clk_i) disable iff (rst_i) b_valid_i |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_mseq_store_txn_sched.sv
// -----------------------------------------------------------------------------
// tb_mseq_store_txn_sched
//
// Self-checking bench for mseq_store_txn_sched. It configures 512-bit data
// and a 4 KiB boundary, with one burst allowed in flight. A directed table
// covers the characteristic requests. Hand-written sequences cover a reset
// during the beat phase. Randomised requests run with random back-pressure.
// Every handshake is scored against a reference model that derives the burst
// list from nibble ranges.
// -----------------------------------------------------------------------------
module tb_mseq_store_txn_sched;

  localparam int unsigned AxiDataWidth   = 512;
  localparam int unsigned AxiAddrWidth   = 64;
  localparam int unsigned LenWidth       = 32;
  localparam int unsigned MaxBurstBeats  = 16;
  localparam int unsigned BoundaryBytes  = 4096;
  localparam int unsigned MaxOutstanding = 1;
  localparam int unsigned BusNSize       = 7;
  localparam longint unsigned BeatNib    = 128;
  localparam longint unsigned BndNib     = 2 * BoundaryBytes;
  localparam longint unsigned BurstNib   = MaxBurstBeats * BeatNib;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AxiAddrWidth:0]   req_addr_i;
  logic [LenWidth-1:0]     req_nbs_i;
  logic                    aw_valid_o;
  logic                    aw_ready_i;
  logic [AxiAddrWidth-1:0] aw_addr_o;
  logic [7:0]              aw_len_o;
  logic [2:0]              aw_size_o;
  logic                    txn_valid_o;
  logic                    txn_ready_i;
  logic [AxiAddrWidth:0]   txn_addr_o;
  logic                    txn_is_head_o;
  logic [7:0]              txn_rmn_beat_o;
  logic [BusNSize:0]       txn_lbn_o;
  logic                    txn_is_final_o;
  logic                    b_valid_i;
  logic                    b_ready_o;
  logic                    busy_o;
  logic                    done_o;

  always #5 clk_i = ~clk_i;

  mseq_store_txn_sched #(
    .AxiDataWidth  (AxiDataWidth),
    .AxiAddrWidth  (AxiAddrWidth),
    .LenWidth      (LenWidth),
    .MaxBurstBeats (MaxBurstBeats),
    .BoundaryBytes (BoundaryBytes),
    .MaxOutstanding(MaxOutstanding)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_nbs_i     (req_nbs_i),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .aw_addr_o     (aw_addr_o),
    .aw_len_o      (aw_len_o),
    .aw_size_o     (aw_size_o),
    .txn_valid_o   (txn_valid_o),
    .txn_ready_i   (txn_ready_i),
    .txn_addr_o    (txn_addr_o),
    .txn_is_head_o (txn_is_head_o),
    .txn_rmn_beat_o(txn_rmn_beat_o),
    .txn_lbn_o     (txn_lbn_o),
    .txn_is_final_o(txn_is_final_o),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // ---------------------------------------------------------------- model
  typedef struct {
    longint unsigned addr;
    int unsigned     beats;
  } burst_t;

  typedef struct {
    int unsigned     burst;
    bit              head;
    int unsigned     rmn;
    longint unsigned addr;
    int unsigned     lbn;
    bit              fin;
  } beat_t;

  burst_t exp_aw[$];
  beat_t  exp_beat[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: request in flight, bursts in flight, AWs seen for the request
  bit          active;
  int unsigned out_cnt;
  int unsigned aw_cnt;
  int unsigned done_cnt;

  // Captures for the directed table
  longint unsigned first_aw_addr, last_addr;
  int unsigned     first_len, first_lbn, last_lbn;
  bit              got_first_beat;

  // Stimulus knobs and counters
  int unsigned aw_delay, aw_pct, txn_pct, b_delay, b_pct;
  int unsigned aw_wait, b_wait;
  bit              req_pend;
  longint unsigned req_a, req_n;

  // Previous-cycle stall snapshots for the stability checks
  bit              pa_stall, pt_stall;
  longint unsigned pa_addr, pt_addr;
  int unsigned     pa_len, pt_rmn, pt_lbn;
  bit              pt_head, pt_fin;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit pct(input int unsigned p);
    return $urandom_range(0, 99) < p;
  endfunction

  // A burst ends at the first of three limits. The first is the end of the
  // request. The second is the next 8192-nibble line. The third is
  // MaxBurstBeats whole beats past the beat holding the burst start. The beat
  // count is the number of 128-nibble beats touched. lbn is how far the end
  // reaches into its last beat.
  task automatic build_model(input longint unsigned addr, input longint unsigned nbs);
    longint unsigned a, e, lim, first_beat, last_beat;
    int unsigned     idx;
    burst_t          b;
    beat_t           t;
    a   = addr;
    idx = 0;
    exp_aw.delete();
    exp_beat.delete();
    while (a < addr + nbs) begin
      e          = addr + nbs;
      lim        = (a / BndNib + 1) * BndNib;
      if (lim < e) e = lim;
      first_beat = a / BeatNib;
      lim        = first_beat * BeatNib + BurstNib;
      if (lim < e) e = lim;
      last_beat  = (e - 1) / BeatNib;
      b.addr     = a;
      b.beats    = int'(last_beat - first_beat + 1);
      exp_aw.push_back(b);
      for (int i = 0; i < b.beats; i++) begin
        t.burst = idx;
        t.head  = (i == 0);
        t.rmn   = b.beats - 1 - i;
        t.addr  = a;
        t.lbn   = int'(e - last_beat * BeatNib);
        t.fin   = (e == addr + nbs);
        exp_beat.push_back(t);
      end
      a = e;
      idx++;
    end
  endtask

  // One clock cycle. On entry we sit just after a rising edge. The task
  // checks the outputs against the model and picks this cycle's inputs. It
  // scores the handshakes that the next edge will complete, then advances.
  task automatic step();
    bit          exp_done, aw_hs;
    burst_t      b;
    beat_t       t;
    check("b_ready", b_ready_o, 1'b1);
    check("req_ready", req_ready_o, !active);
    check("busy", busy_o, active);
    exp_done = active && (exp_beat.size() == 0) && (out_cnt == 0);
    check("done", done_o, exp_done);
    if (aw_valid_o) check("aw_size", aw_size_o, 3'd6);
    if (pa_stall) begin
      check("aw_hold_valid", aw_valid_o, 1'b1);
      check("aw_hold_addr", aw_addr_o, pa_addr);
      check("aw_hold_len", aw_len_o, pa_len);
    end
    if (pt_stall) begin
      check("txn_hold_valid", txn_valid_o, 1'b1);
      check("txn_hold_addr", txn_addr_o, pt_addr);
      check("txn_hold_head", txn_is_head_o, pt_head);
      check("txn_hold_rmn", txn_rmn_beat_o, pt_rmn);
      check("txn_hold_lbn", txn_lbn_o, pt_lbn);
      check("txn_hold_final", txn_is_final_o, pt_fin);
    end

    req_valid_i = req_pend;
    req_addr_i  = (AxiAddrWidth+1)'(req_a);
    req_nbs_i   = LenWidth'(req_n);
    aw_ready_i  = (aw_wait >= aw_delay) && pct(aw_pct);
    txn_ready_i = pct(txn_pct);
    b_valid_i   = (out_cnt > 0) && (b_wait >= b_delay) && pct(b_pct);

    if (req_valid_i && req_ready_o) begin
      active         = 1'b1;
      req_pend       = 1'b0;
      aw_cnt         = 0;
      got_first_beat = 1'b0;
      build_model(req_a, req_n);
    end

    // Ordering is judged against AWs completed on earlier edges only.
    if (txn_valid_o) begin
      check("txn_expected", exp_beat.size() != 0, 1'b1);
      if (exp_beat.size() != 0) begin
        check("txn_after_aw", aw_cnt > exp_beat[0].burst, 1'b1);
        if (txn_ready_i) begin
          t = exp_beat.pop_front();
          check("txn_addr", txn_addr_o, t.addr);
          check("txn_head", txn_is_head_o, t.head);
          check("txn_rmn", txn_rmn_beat_o, t.rmn);
          check("txn_lbn", txn_lbn_o, t.lbn);
          check("txn_final", txn_is_final_o, t.fin);
          if (!got_first_beat) begin
            first_lbn      = txn_lbn_o;
            got_first_beat = 1'b1;
          end
          if (txn_is_final_o && txn_rmn_beat_o == 8'd0) begin
            last_addr = txn_addr_o;
            last_lbn  = txn_lbn_o;
          end
        end
      end
    end

    aw_hs = aw_valid_o && aw_ready_i;
    if (aw_hs) begin
      check("aw_out_limit", out_cnt < MaxOutstanding, 1'b1);
      check("aw_expected", exp_aw.size() != 0, 1'b1);
      if (exp_aw.size() != 0) begin
        b = exp_aw.pop_front();
        check("aw_addr", aw_addr_o, b.addr >> 1);
        check("aw_len", aw_len_o, b.beats - 1);
      end
      if (aw_cnt == 0) begin
        first_aw_addr = aw_addr_o;
        first_len     = aw_len_o;
      end
      aw_cnt++;
      aw_wait = 0;
    end else if (aw_valid_o) begin
      aw_wait++;
    end

    if (b_valid_i) begin
      out_cnt--;
      b_wait = 0;
    end else if (out_cnt > 0) begin
      b_wait++;
    end
    if (aw_hs) out_cnt++;

    if (exp_done) begin
      active = 1'b0;
      done_cnt++;
    end

    pa_stall = aw_valid_o && !aw_ready_i;
    pa_addr  = aw_addr_o;
    pa_len   = aw_len_o;
    pt_stall = txn_valid_o && !txn_ready_i;
    pt_addr  = txn_addr_o;
    pt_head  = txn_is_head_o;
    pt_rmn   = txn_rmn_beat_o;
    pt_lbn   = txn_lbn_o;
    pt_fin   = txn_is_final_o;

    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    aw_ready_i  = 1'b0;
    txn_ready_i = 1'b0;
    b_valid_i   = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #1;
    check("rst_b_ready", b_ready_o, 1'b0);
    check("rst_aw_valid", aw_valid_o, 1'b0);
    check("rst_txn_valid", txn_valid_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req_ready", req_ready_o, 1'b1);
    active   = 1'b0;
    out_cnt  = 0;
    aw_cnt   = 0;
    aw_wait  = 0;
    b_wait   = 0;
    req_pend = 1'b0;
    pa_stall = 1'b0;
    pt_stall = 1'b0;
    exp_aw.delete();
    exp_beat.delete();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic run_request(input longint unsigned a, input longint unsigned n,
                             input int unsigned budget);
    int unsigned dc;
    dc       = done_cnt;
    req_pend = 1'b1;
    req_a    = a;
    req_n    = n;
    for (int c = 0; c < budget && done_cnt == dc; c++) step();
    check("req_done_in_time", done_cnt != dc, 1'b1);
    if (done_cnt == dc) do_reset(2);
  endtask

  task automatic set_knobs(input int unsigned awd, input int unsigned awp, input int unsigned tp,
                           input int unsigned bd, input int unsigned bp);
    aw_delay = awd;
    aw_pct   = awp;
    txn_pct  = tp;
    b_delay  = bd;
    b_pct    = bp;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    longint unsigned addr;
    longint unsigned nbs;
    int unsigned     aw_delay;
    int unsigned     txn_pct;
    int unsigned     b_delay;
    int unsigned     bursts;
    longint unsigned aw_addr0;
    int unsigned     len0;
    int unsigned     lbn0;
    longint unsigned last_addr;
    int unsigned     last_lbn;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // addr, nbs, aw_delay, txn_pct, b_delay, bursts, aw_addr0, len0, lbn0, last_addr, last_lbn
    vecs[0] = '{64'd0,    64'd128,  0, 100, 0,  1, 64'd0,    0,  128, 64'd0,    128};
    vecs[1] = '{64'd16,   64'd300,  0, 100, 0,  1, 64'd8,    2,  60,  64'd16,   60};
    vecs[2] = '{64'd8100, 64'd200,  0, 100, 0,  2, 64'd4050, 0,  128, 64'd8192, 108};
    vecs[3] = '{64'd0,    64'd2100, 0, 100, 0,  2, 64'd0,    15, 128, 64'd2048, 52};
    vecs[4] = '{64'd64,   64'd5000, 5, 50,  10, 3, 64'd32,   15, 128, 64'd4096, 72};

    done_cnt = 0;
    req_a    = 0;
    req_n    = 0;
    set_knobs(0, 100, 100, 0, 100);
    do_reset(3);

    for (int v = 0; v < 5; v++) begin
      set_knobs(vecs[v].aw_delay, 100, vecs[v].txn_pct, vecs[v].b_delay, 100);
      run_request(vecs[v].addr, vecs[v].nbs, 3000);
      check("vec_bursts", aw_cnt, vecs[v].bursts);
      check("vec_aw_addr0", first_aw_addr, vecs[v].aw_addr0);
      check("vec_len0", first_len, vecs[v].len0);
      check("vec_lbn0", first_lbn, vecs[v].lbn0);
      check("vec_last_addr", last_addr, vecs[v].last_addr);
      check("vec_last_lbn", last_lbn, vecs[v].last_lbn);
      step();
      step();
    end

    // Reset in the middle of a 16-beat burst, with its B still withheld.
    // The scheduler must come back clean and accept a fresh request at once.
    set_knobs(0, 100, 50, 0, 0);
    req_pend = 1'b1;
    req_a    = 0;
    req_n    = 2100;
    for (int c = 0; c < 300 && !(active && exp_beat.size() <= 14); c++) step();
    check("mid_beats_valid", txn_valid_o, 1'b1);
    do_reset(1);
    set_knobs(0, 100, 100, 0, 100);
    run_request(64'd0, 64'd128, 200);
    check("post_rst_bursts", aw_cnt, 1);
    check("post_rst_lbn", last_lbn, 128);

    // Randomised requests near boundaries with random back-pressure.
    for (int r = 0; r < 30; r++) begin
      longint unsigned a, n;
      a = longint'($urandom_range(0, 4)) * BndNib + longint'($urandom_range(0, 8191));
      if ($urandom_range(0, 3) == 0) a += longint'($urandom_range(1, 255)) << 32;
      n = ($urandom_range(0, 2) == 0) ? longint'($urandom_range(1, 130))
                                      : longint'($urandom_range(1, 5000));
      set_knobs($urandom_range(0, 3), $urandom_range(50, 100), $urandom_range(30, 100),
                $urandom_range(0, 6), $urandom_range(30, 100));
      run_request(a, n, 6000);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mseq_store_txn_sched.md
Name: mseq_store_txn_sched

Overview:
Burst scheduler for the matrix sequential-store path.
- Accepts one store request: nibble start address plus total nibble count.
- Splits it into AXI write bursts that never cross a BoundaryBytes boundary and never exceed MaxBurstBeats beats.
- Issues one AW per burst, then a per-beat transaction-control stream (head flag, remaining beats, last-beat nibble bound, final-burst flag) to the store datapath that packs W beats.
- Tracks outstanding B responses and pulses done_o when the whole request has completed.

Parameters:
- AxiDataWidth, 512, W data width in bits. busNibbles = AxiDataWidth/4; busNSize = log2(busNibbles).
- AxiAddrWidth, 64, AXI address width in bits.
- LenWidth, 32, width of the request nibble count.
- MaxBurstBeats, 16, maximum beats per burst; power of 2, at most 256.
- BoundaryBytes, 4096, burst-crossing boundary in bytes; power of 2, at least AxiDataWidth/8*MaxBurstBeats.
- MaxOutstanding, 8, maximum number of bursts with AW issued but B not yet received.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted; high only in IDLE.
- req_addr_i  in  AxiAddrWidth+1  start address in nibbles.
- req_nbs_i  in  LenWidth  total nibbles to store; must be nonzero.
- aw_valid_o  out  1  AW valid.
- aw_ready_i  in  1  AW ready.
- aw_addr_o  out  AxiAddrWidth  byte address = burst nibble address >> 1.
- aw_len_o  out  8  beats minus 1.
- aw_size_o  out  3  constant log2(AxiDataWidth/8).
- txn_valid_o  out  1  beat control valid.
- txn_ready_i  in  1  datapath consumed the beat.
- txn_addr_o  out  AxiAddrWidth+1  nibble address of the current burst start.
- txn_is_head_o  out  1  first beat of the burst.
- txn_rmn_beat_o  out  8  beats remaining after this one.
- txn_lbn_o  out  busNSize+1  exclusive upper nibble of the burst's last beat, range 1..busNibbles.
- txn_is_final_o  out  1  this burst is the request's last.
- b_valid_i  in  1  B response valid.
- b_ready_o  out  1  always 1 outside reset.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse on request completion.

Behaviour:
Reset (rst_i high at a clock edge):
- State goes to IDLE; all counters clear.
- All valid outputs, busy_o and done_o go to 0; b_ready_o goes to 0 during reset.
- Any in-flight request is dropped with no done_o.

States IDLE, CALC, AW, BEATS, WAIT_B:
- IDLE: req_ready_o=1. On req handshake, latch cur_addr=req_addr_i and rmn=req_nbs_i, then go to CALC.
- CALC (1 cycle): compute burst fields into registers. If outstanding==MaxOutstanding, stay in CALC.
- AW: aw_valid_o=1. Fields stay stable until aw_ready_i. On handshake, outstanding+1 and go to BEATS.
- BEATS: txn_valid_o=1.
  - On each txn handshake, rmn_beat decrements and head clears.
  - On the handshake with rmn_beat==0: cur_addr += chunk and rmn -= chunk.
  - Then go to WAIT_B if the burst was final, else CALC.
- WAIT_B: when outstanding==0, assert done_o for 1 cycle and go to IDLE.

Burst arithmetic (CALC, in nibbles, unsigned):
- off = cur_addr mod busNibbles.
- to_bnd = 2*BoundaryBytes - (cur_addr mod 2*BoundaryBytes).
- max_nb = MaxBurstBeats*busNibbles - off.
- chunk = min(rmn, to_bnd, max_nb).
- beats = ceil((off+chunk)/busNibbles); aw_len = beats-1.
- lbn = ((off+chunk-1) mod busNibbles)+1.
- final = (rmn==chunk).
- All intermediates are wide enough to hold 2*BoundaryBytes+busNibbles without overflow.

Per-beat control:
- txn_is_head_o=1 only on the first beat of each burst.
- txn_rmn_beat_o starts at aw_len and counts down to 0.
- txn_lbn_o, txn_addr_o and txn_is_final_o are constant for the burst.

Outstanding counter:
- +1 on AW handshake, -1 on B handshake.
- Both in the same cycle: net 0.
- Must never underflow; a B with outstanding==0 is a protocol error and is flagged by an assertion.

AW/beat ordering: beat control for a burst is never presented before that burst's AW handshake. This holds even when aw_ready_i is low for many cycles.

Valid/data stability: every output valid, once asserted, stays high with stable data until its ready is seen.

Test Plan (AxiDataWidth=512, so busNibbles=128; 4KB boundary = 8192 nibbles; MaxBurstBeats=16):
- Single aligned beat: addr 0, nbs 128 -> AW addr 0 len 0; one beat head=1 rmn=0 lbn=128 final=1; done_o 1 cycle after the B.
- Unaligned multi-beat: addr 16, nbs 300 -> AW addr 8 len 2; beats rmn 2,1,0; head only on the first; lbn=60; final=1.
- Boundary split: addr 8100, nbs 200 -> first AW len 0, lbn 128, final 0. Second burst: txn_addr 8192, AW addr 4096, len 0, lbn 108, final 1.
- Max-burst split: addr 0, nbs 2100 -> burst 1 AW len 15, lbn 128, final 0. Burst 2 AW addr 1024, len 0, lbn 52, final 1. done_o only after both B responses.
- Backpressure and outstanding limit: MaxOutstanding=1, B withheld 10 cycles, aw_ready low 5 cycles, txn_ready toggled -> second AW waits for the first B; outputs stay stable under stall; req_ready_o stays 0 until done.
- Reset mid-BEATS -> on the next cycle all valids are 0, req_ready_o=1, outstanding=0; a new request then behaves as from cold.
